// File: rtl/spi_master_core.sv
// spi_master_core: byte-oriented mode-0 (CPOL=0, CPHA=0) SPI master shift engine.
// Accepts one transfer per start strobe, drives a one-hot active-low slave select,
// and returns the received word with a single-cycle done pulse.
// Optional build macro: SPI_LSB_FIRST_EN -- when defined, bit 0 is shifted first on
// MOSI and received bits fill rx_data from bit 0 upward; otherwise MSB first.
// DATA_W must be at least 2.

module spi_master_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_SS = 8,
    parameter int unsigned DIV_W  = 8,
    localparam int unsigned SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic [DIV_W-1:0]  clk_div,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              MOSI,
    input  logic              MISO,
    output logic              SCLK,
    output logic [0:NUM_SS-1] SS
);

    // Half-period index covers 2*DATA_W SCLK phases.
    localparam int unsigned HP_W = $clog2(2 * DATA_W);
    localparam logic [HP_W-1:0] HpLast = HP_W'(2 * DATA_W - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSetup = 3'd1;
    localparam logic [2:0] StShift = 3'd2;
    localparam logic [2:0] StHold  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;     // counts down the current H-cycle phase
    logic [DIV_W-1:0]  div_q, div_d;     // divider latched at accept
    logic [SS_W-1:0]   ss_q, ss_d;       // slave index latched at accept
    logic [HP_W-1:0]   hp_q, hp_d;       // current half-period within SHIFT
    logic              sclk_q, sclk_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_q, rx_d;

    logic              tick;
    logic              active;
    logic              mosi_bit;
    logic [DATA_W-1:0] tx_adv;
    logic [DATA_W-1:0] rx_ins;

    assign tick   = (cnt_q == '0);
    assign active = (state_q == StSetup) || (state_q == StShift) || (state_q == StHold);

`ifdef SPI_LSB_FIRST_EN
    assign mosi_bit = tx_sh_q[0];
    assign tx_adv   = {1'b0, tx_sh_q[DATA_W-1:1]};
    assign rx_ins   = {MISO, rx_sh_q[DATA_W-1:1]};
`else
    assign mosi_bit = tx_sh_q[DATA_W-1];
    assign tx_adv   = {tx_sh_q[DATA_W-2:0], 1'b0};
    assign rx_ins   = {rx_sh_q[DATA_W-2:0], MISO};
`endif

    // Transfer sequencing: phase timing, SCLK toggling, MISO sampling and MOSI advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        ss_d    = ss_q;
        hp_d    = hp_q;
        sclk_d  = sclk_q;
        tx_sh_d = tx_sh_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSetup;
                    cnt_d   = clk_div;
                    div_d   = clk_div;
                    ss_d    = ss_sel;
                    tx_sh_d = tx_data;
                end
            end

            StSetup: begin
                if (tick) begin
                    // First SCLK rise: sample the first MISO bit on the same edge.
                    state_d = StShift;
                    cnt_d   = div_q;
                    hp_d    = '0;
                    sclk_d  = 1'b1;
                    rx_sh_d = rx_ins;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end

            StShift: begin
                if (tick) begin
                    cnt_d = div_q;
                    if (hp_q == HpLast) begin
                        state_d = StHold;
                    end else begin
                        hp_d   = hp_q + HP_W'(1);
                        sclk_d = ~sclk_q;
                        if (!sclk_q) begin
                            rx_sh_d = rx_ins;
                        end else if (hp_q != HpLast - HP_W'(1)) begin
                            // The final falling edge leaves the last bit on MOSI.
                            tx_sh_d = tx_adv;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end

            StHold: begin
                if (tick) begin
                    state_d = StDone;
                    rx_d    = rx_sh_q;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset returns every output to idle immediately.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= '0;
            ss_q    <= '0;
            hp_q    <= '0;
            sclk_q  <= 1'b0;
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            ss_q    <= ss_d;
            hp_q    <= hp_d;
            sclk_q  <= sclk_d;
            tx_sh_q <= tx_sh_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
        end
    end

    // One-hot active-low select; an out-of-range index matches no line.
    always_comb begin
        SS = '1;
        for (int i = 0; i < int'(NUM_SS); i++) begin
            SS[i] = ~(active && (ss_q == SS_W'(i)));
        end
    end

    assign busy    = active;
    assign done    = (state_q == StDone);
    assign rx_data = rx_q;
    assign SCLK    = sclk_q;
    assign MOSI    = active & mosi_bit;

endmodule

// File: tb/tb_spi_master_core.sv
// Self-checking bench for spi_master_core with a mode-0 slave model and an rx scoreboard.
// A second instance with NUM_SS=9 exercises an out-of-range slave index (ss_sel=9).
module tb_spi_master_core;

    logic       ACLK;
    logic       ARESETN;
    logic       start;
    logic [7:0] tx_data;
    logic [2:0] ss_sel;
    logic [7:0] clk_div;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       MOSI;
    logic       MISO;
    logic       SCLK;
    logic [0:7] SS;

    logic [3:0] ss_sel2;
    logic       busy2;
    logic       done2;
    logic [7:0] rx2;
    logic       mosi2;
    logic       sclk2;
    logic [0:8] ss2;

    int checks;
    int failures;
    int cyc;

    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];

    // Slave model state
    logic [7:0] slave_byte;
    int         sl_idx;
    logic       sclk_prev;

    // Observations gathered by run_xfer
    logic [7:0] obs_mosi;
    int         obs_rises;
    int         obs_rise1;
    int         obs_hi;
    int         obs_lo;
    int         obs_done_cyc;
    int         obs_done_cnt;
    logic [0:7] obs_ss;
    bit         obs_ss_var;
    bit         obs_mosi_or;
    bit         obs_ovl;
    logic [7:0] obs_rx;

    spi_master_core u_dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .start   (start),
        .tx_data (tx_data),
        .ss_sel  (ss_sel),
        .clk_div (clk_div),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .SCLK    (SCLK),
        .SS      (SS)
    );

    spi_master_core #(.NUM_SS(9)) u_dut9 (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .start   (start),
        .tx_data (tx_data),
        .ss_sel  (ss_sel2),
        .clk_div (clk_div),
        .busy    (busy2),
        .done    (done2),
        .rx_data (rx2),
        .MOSI    (mosi2),
        .MISO    (MISO),
        .SCLK    (sclk2),
        .SS      (ss2)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    // Bits of a word in the order they travel on the wire, first bit at [7].
    function automatic logic [7:0] wire_order(input logic [7:0] b);
        logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[7-i] = b[i];
`else
        r = b;
`endif
        return r;
    endfunction

    // Mode-0 slave: presents the next bit after each SCLK fall, restarts when not busy.
    always @(negedge ACLK) begin
        logic [7:0] w;
        if (!busy) sl_idx = 0;
        else if (sclk_prev && !SCLK) sl_idx = sl_idx + 1;
        sclk_prev = SCLK;
        w = wire_order(slave_byte);
        MISO = (sl_idx < 8) ? w[7-sl_idx] : 1'b0;
    end

    // Drives one transfer and records what the pins did over `window` cycles.
    task automatic run_xfer(input logic [7:0] tx, input logic [2:0] sel, input logic [7:0] div,
                            input logic [7:0] sb, input int window, input int pulse_k,
                            input logic [7:0] pulse_tx);
        int   hl;
        int   ll;
        logic prev;
        bit   ss_seen;
        slave_byte = sb;
        @(negedge ACLK);
        tx_data = tx;
        ss_sel  = sel;
        clk_div = div;
        start   = 1'b1;
        exp_q.push_back(sb);
        obs_mosi = '0; obs_rises = 0; obs_rise1 = -1; obs_hi = -1; obs_lo = -1;
        obs_done_cyc = -1; obs_done_cnt = 0; obs_ss = '1; obs_ss_var = 0;
        obs_mosi_or = 0; obs_ovl = 0; obs_rx = 'x;
        prev = 1'b0; hl = 0; ll = 0; ss_seen = 0;
        for (int k = 1; k <= window; k++) begin
            @(negedge ACLK);
            if (k == pulse_k) begin
                start   = 1'b1;
                tx_data = pulse_tx;
            end else begin
                start = 1'b0;
            end
            if (SCLK === 1'b1) begin
                if (!prev) begin
                    obs_rises++;
                    if (obs_rises == 1) obs_rise1 = k;
                    else obs_lo = ll;
                    obs_mosi = {obs_mosi[6:0], MOSI};
                end
                hl++;
                ll = 0;
            end else begin
                if (prev) begin
                    obs_hi = hl;
                    hl = 0;
                end
                ll++;
            end
            prev = SCLK;
            if (busy) begin
                if (!ss_seen) begin
                    obs_ss  = SS;
                    ss_seen = 1;
                end else if (SS !== obs_ss) begin
                    obs_ss_var = 1;
                end
            end
            if (MOSI) obs_mosi_or = 1;
            if (busy && done) obs_ovl = 1;
            if (done) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc = k;
                    obs_rx = rx_data;
                end
            end
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (3) @(negedge ACLK);
        checks += 6;
        if (SS !== 8'hFF) begin failures++; $display("FAIL reset_ss: got %h want ff", SS); end
        if (SCLK !== 1'b0) begin failures++; $display("FAIL reset_sclk: got %b want 0", SCLK); end
        if (MOSI !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        if (rx_data !== 8'h00) begin
            failures++; $display("FAIL reset_rx: got %h want 00", rx_data);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
    endtask

    task automatic test_basic();
        logic [7:0] tx_t[3];
        logic [2:0] sel_t[3];
        logic [7:0] sb_t[3];
        logic [7:0] exp_mosi;
        logic [0:7] exp_ss;
        logic [7:0] exp;
        tx_t  = '{8'hA5, 8'h5A, 8'h01};
        sel_t = '{3'd2, 3'd7, 3'd0};
        sb_t  = '{8'h3C, 8'hC3, 8'h80};
        for (int i = 0; i < 3; i++) begin
            run_xfer(tx_t[i], sel_t[i], 8'd0, sb_t[i], 24, 0, 8'h00);
            exp_mosi = wire_order(tx_t[i]);
            exp_ss = '1;
            exp_ss[sel_t[i]] = 1'b0;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks += 9;
            if (obs_mosi !== exp_mosi) begin
                failures++; $display("FAIL basic_mosi[%0d]: got %h want %h", i, obs_mosi, exp_mosi);
            end
            if (obs_ss !== exp_ss || obs_ss_var) begin
                failures++; $display("FAIL basic_ss[%0d]: got %b (varied=%0d) want %b", i, obs_ss,
                                     obs_ss_var, exp_ss);
            end
            if (obs_rises != 8) begin
                failures++; $display("FAIL basic_rises[%0d]: got %0d want 8", i, obs_rises);
            end
            if (obs_rise1 != 2) begin
                failures++; $display("FAIL basic_rise1[%0d]: got %0d want 2", i, obs_rise1);
            end
            if (obs_done_cyc != 19) begin
                failures++; $display("FAIL basic_done_cyc[%0d]: got %0d want 19", i, obs_done_cyc);
            end
            if (obs_done_cnt != 1) begin
                failures++; $display("FAIL basic_done_cnt[%0d]: got %0d want 1", i, obs_done_cnt);
            end
            if (obs_ovl) begin
                failures++; $display("FAIL basic_overlap[%0d]: got busy&done want never", i);
            end
            if (obs_hi != 1 || obs_lo != 1) begin
                failures++; $display("FAIL basic_half[%0d]: got hi=%0d lo=%0d want 1/1", i, obs_hi,
                                     obs_lo);
            end
            if (obs_rx !== exp) begin
                failures++; $display("FAIL basic_rx[%0d]: got %h want %h", i, obs_rx, exp);
            end
        end
    endtask

    task automatic test_divider();
        logic [7:0] exp;
        run_xfer(8'h96, 3'd5, 8'd3, 8'h5B, 80, 0, 8'h00);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks += 6;
        if (obs_hi != 4) begin failures++; $display("FAIL div_high: got %0d want 4", obs_hi); end
        if (obs_lo != 4) begin failures++; $display("FAIL div_low: got %0d want 4", obs_lo); end
        if (obs_rises != 8) begin failures++; $display("FAIL div_rises: got %0d want 8", obs_rises); end
        if (obs_rise1 != 5) begin failures++; $display("FAIL div_rise1: got %0d want 5", obs_rise1); end
        if (obs_done_cyc != 73) begin
            failures++; $display("FAIL div_done_cyc: got %0d want 73", obs_done_cyc);
        end
        if (obs_rx !== exp) begin failures++; $display("FAIL div_rx: got %h want %h", obs_rx, exp); end
    endtask

    task automatic test_busy_reject();
        logic [7:0] exp;
        run_xfer(8'h00, 3'd1, 8'd0, 8'hC5, 45, 5, 8'hFF);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks += 4;
        if (obs_mosi_or) begin failures++; $display("FAIL reject_mosi: got 1 seen want 0 always"); end
        if (obs_done_cnt != 1) begin
            failures++; $display("FAIL reject_done_cnt: got %0d want 1", obs_done_cnt);
        end
        if (obs_done_cyc != 19) begin
            failures++; $display("FAIL reject_done_cyc: got %0d want 19", obs_done_cyc);
        end
        if (obs_rx !== exp) begin failures++; $display("FAIL reject_rx: got %h want %h", obs_rx, exp); end
    endtask

    task automatic test_mid_reset();
        int         dcnt;
        logic [7:0] exp;
        slave_byte = 8'hE7;
        @(negedge ACLK);
        tx_data = 8'hFF;
        ss_sel  = 3'd4;
        clk_div = 8'd0;
        start   = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        repeat (9) @(negedge ACLK);
        // cycle 10: mid SHIFT, SCLK high
        checks += 2;
        if (SCLK !== 1'b1) begin failures++; $display("FAIL midrst_pre_sclk: got %b want 1", SCLK); end
        if (busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
        ARESETN = 1'b0;
        #1;
        checks += 6;
        if (SS !== 8'hFF) begin failures++; $display("FAIL midrst_ss: got %h want ff", SS); end
        if (SCLK !== 1'b0) begin failures++; $display("FAIL midrst_sclk: got %b want 0", SCLK); end
        if (MOSI !== 1'b0) begin failures++; $display("FAIL midrst_mosi: got %b want 0", MOSI); end
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b want 0", done); end
        if (rx_data !== 8'h00) begin
            failures++; $display("FAIL midrst_rx: got %h want 00", rx_data);
        end
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge ACLK);
            if (done) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin failures++; $display("FAIL midrst_no_done: got %0d want 0", dcnt); end
        run_xfer(8'h3A, 3'd4, 8'd0, 8'h69, 24, 0, 8'h00);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks += 3;
        if (obs_done_cyc != 19) begin
            failures++; $display("FAIL midrst_after_done: got %0d want 19", obs_done_cyc);
        end
        if (obs_mosi !== wire_order(8'h3A)) begin
            failures++; $display("FAIL midrst_after_mosi: got %h want %h", obs_mosi, wire_order(8'h3A));
        end
        if (obs_rx !== exp) begin failures++; $display("FAIL midrst_after_rx: got %h want %h", obs_rx, exp); end
    endtask

    task automatic test_back_to_back();
        int         c0;
        int         n2;
        int         n1;
        int         d2[8];
        int         ss_bad;
        int         lock_bad;
        int         ovl;
        logic [7:0] exp;
        slave_byte = 8'h2D;
        repeat (4) exp2_q.push_back(8'h2D);
        repeat (4) exp_q.push_back(8'h2D);
        n2 = 0; n1 = 0; ss_bad = 0; lock_bad = 0; ovl = 0;
        @(negedge ACLK);
        tx_data = 8'h71;
        ss_sel  = 3'd6;
        ss_sel2 = 4'd9;
        clk_div = 8'd0;
        start   = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 85; k++) begin
            @(negedge ACLK);
            if (k == 65) start = 1'b0;
            if (ss2 !== 9'h1FF) ss_bad++;
            if (sclk2 !== SCLK || mosi2 !== MOSI || busy2 !== busy) lock_bad++;
            if (busy2 && done2) ovl++;
            if (done2) begin
                if (n2 < 8) d2[n2] = cyc - c0;
                n2++;
                exp = (exp2_q.size() > 0) ? exp2_q.pop_front() : 8'hxx;
                checks++;
                if (rx2 !== exp) begin failures++; $display("FAIL b2b_rx_ss9: got %h want %h", rx2, exp); end
            end
            if (done) begin
                n1++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checks++;
                if (rx_data !== exp) begin
                    failures++; $display("FAIL b2b_rx: got %h want %h", rx_data, exp);
                end
            end
        end
        checks += 5;
        if (n2 != 4 || n1 != 4) begin
            failures++; $display("FAIL b2b_done_cnt: got %0d/%0d want 4/4", n2, n1);
        end
        if (ss_bad != 0) begin failures++; $display("FAIL b2b_ss_invalid: got %0d low cycles want 0", ss_bad); end
        if (lock_bad != 0) begin failures++; $display("FAIL b2b_lockstep: got %0d diffs want 0", lock_bad); end
        if (ovl != 0) begin failures++; $display("FAIL b2b_overlap: got %0d want 0", ovl); end
        if (n2 >= 4 && (d2[0] != 19 || d2[1] != 39 || d2[2] != 59 || d2[3] != 79)) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d,%0d,%0d,%0d want 19,39,59,79", d2[0], d2[1], d2[2], d2[3]);
        end else if (n2 < 4) begin
            failures++; $display("FAIL b2b_spacing: got %0d pulses want 4", n2);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        start      = 1'b0;
        tx_data    = 8'h00;
        ss_sel     = 3'd0;
        ss_sel2    = 4'd9;
        clk_div    = 8'd0;
        slave_byte = 8'h00;
        sl_idx     = 0;
        sclk_prev  = 1'b0;
        MISO       = 1'b0;
        test_reset();
        test_basic();
        test_divider();
        test_busy_reject();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
